// File: rtl/tlight_junction_ctrl.sv
// Two-road UK traffic-light junction sequencer with tick-timed phases.
// Define TLIGHT_PED_EN to compile in the pedestrian WALK phase, request latch and next-road flag.
module tlight_junction_ctrl #(
    parameter int unsigned GREEN_TICKS     = 20,
    parameter int unsigned AMBER_TICKS     = 3,
    parameter int unsigned RED_AMBER_TICKS = 2,
    parameter int unsigned ALL_RED_TICKS   = 1,
    parameter int unsigned WALK_TICKS      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic ped_req,
    output logic a_r,
    output logic a_a,
    output logic a_g,
    output logic b_r,
    output logic b_a,
    output logic b_g,
    output logic walk,
    output logic ped_wait
);

    localparam int unsigned MaxGA    = (GREEN_TICKS > AMBER_TICKS) ? GREEN_TICKS : AMBER_TICKS;
    localparam int unsigned MaxRW    = (RED_AMBER_TICKS > WALK_TICKS) ? RED_AMBER_TICKS
                                                                      : WALK_TICKS;
    localparam int unsigned MaxGARW  = (MaxGA > MaxRW) ? MaxGA : MaxRW;
    localparam int unsigned MaxTicks = (MaxGARW > ALL_RED_TICKS) ? MaxGARW : ALL_RED_TICKS;
    // Timer only ever holds duration-1, so clog2 of the longest duration suffices.
    localparam int unsigned TimerW   = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

`ifdef TLIGHT_PED_EN
    typedef enum logic [3:0] {
        StAllRedA,
        StARa,
        StAG,
        StAA,
        StAllRedB,
        StBRa,
        StBG,
        StBA,
        StWalk
    } state_e;
`else
    typedef enum logic [2:0] {
        StAllRedA,
        StARa,
        StAG,
        StAA,
        StAllRedB,
        StBRa,
        StBG,
        StBA
    } state_e;
`endif

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;

    function automatic logic [TimerW-1:0] load_val(input state_e s);
        logic [TimerW-1:0] v;
        v = TimerW'(ALL_RED_TICKS - 1);
        case (s)
            StARa, StBRa: v = TimerW'(RED_AMBER_TICKS - 1);
            StAG, StBG:   v = TimerW'(GREEN_TICKS - 1);
            StAA, StBA:   v = TimerW'(AMBER_TICKS - 1);
`ifdef TLIGHT_PED_EN
            StWalk:       v = TimerW'(WALK_TICKS - 1);
`endif
            default:      v = TimerW'(ALL_RED_TICKS - 1);
        endcase
        return v;
    endfunction

`ifdef TLIGHT_PED_EN
    logic ped_wait_q, ped_wait_d;
    logic next_b_q, next_b_d;
    logic ped_any;
    logic walk_entry;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    // Next-state and timer logic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
`ifdef TLIGHT_PED_EN
        next_b_d = next_b_q;
        ped_any  = ped_wait_q | ped_req;
`endif
        if (tick) begin
            if (timer_q != '0) begin
                timer_d = timer_q - TimerW'(1);
            end else begin
                case (state_q)
                    StAllRedA: begin
                        state_d = StARa;
`ifdef TLIGHT_PED_EN
                        if (ped_any) begin
                            state_d  = StWalk;
                            next_b_d = 1'b0;
                        end
`endif
                    end
                    StARa:     state_d = StAG;
                    StAG:      state_d = StAA;
                    StAA:      state_d = StAllRedB;
                    StAllRedB: begin
                        state_d = StBRa;
`ifdef TLIGHT_PED_EN
                        if (ped_any) begin
                            state_d  = StWalk;
                            next_b_d = 1'b1;
                        end
`endif
                    end
                    StBRa:     state_d = StBG;
                    StBG:      state_d = StBA;
                    StBA:      state_d = StAllRedA;
`ifdef TLIGHT_PED_EN
                    StWalk:    state_d = next_b_q ? StBRa : StARa;
`endif
                    default:   state_d = StAllRedA;
                endcase
                timer_d = load_val(state_d);
            end
        end
    end

`ifdef TLIGHT_PED_EN
    // A request consumed by the transition into WALK is cleared; later ones re-latch.
    always_comb begin
        walk_entry = (state_d == StWalk) && (state_q != StWalk);
        ped_wait_d = walk_entry ? 1'b0 : (ped_wait_q | ped_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ped_wait_q <= 1'b0;
            next_b_q   <= 1'b0;
        end else begin
            ped_wait_q <= ped_wait_d;
            next_b_q   <= next_b_d;
        end
    end

    assign ped_wait = ped_wait_q;
`else
    assign ped_wait = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAllRedA;
            timer_q <= TimerW'(ALL_RED_TICKS - 1);
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Lamp decode straight from the state register
    always_comb begin
        a_r  = 1'b1;
        a_a  = 1'b0;
        a_g  = 1'b0;
        b_r  = 1'b1;
        b_a  = 1'b0;
        b_g  = 1'b0;
        walk = 1'b0;
        case (state_q)
            StARa: a_a = 1'b1;
            StAG: begin
                a_r = 1'b0;
                a_g = 1'b1;
            end
            StAA: begin
                a_r = 1'b0;
                a_a = 1'b1;
            end
            StBRa: b_a = 1'b1;
            StBG: begin
                b_r = 1'b0;
                b_g = 1'b1;
            end
            StBA: begin
                b_r = 1'b0;
                b_a = 1'b1;
            end
`ifdef TLIGHT_PED_EN
            StWalk: walk = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tlight_junction_ctrl.sv
// Randomised and directed bench for tlight_junction_ctrl against a phase-table model.
// Pedestrian scenarios are exercised only when TLIGHT_PED_EN is defined.
module tb_tlight_junction_ctrl;

`ifdef TLIGHT_PED_EN
    localparam bit PedEn = 1'b1;
`else
    localparam bit PedEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b1;
    logic ped_req = 1'b0;
    logic a_r, a_a, a_g, b_r, b_a, b_g, walk, ped_wait;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit toggle_req = 1'b0;
    bit tick_div4 = 1'b0;

    // Model: phase index 0..7 is the fixed cycle, 8 is WALK; elapsed counts ticks spent.
    int m_ph = 0;
    int m_el = 0;
    bit m_wait = 1'b0;
    bit m_nb = 1'b0;
    bit m_valid = 1'b0;

    tlight_junction_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .ped_req  (ped_req),
        .a_r      (a_r),
        .a_a      (a_a),
        .a_g      (a_g),
        .b_r      (b_r),
        .b_a      (b_a),
        .b_g      (b_g),
        .walk     (walk),
        .ped_wait (ped_wait)
    );

    always #5 clk = ~clk;

    function automatic int dur_of(input int ph);
        case (ph)
            0, 4:    return 1;
            1, 5:    return 2;
            2, 6:    return 20;
            3, 7:    return 3;
            default: return 8;
        endcase
    endfunction

    // {a_r, a_a, a_g, b_r, b_a, b_g, walk}
    function automatic logic [6:0] lamps_of(input int ph);
        case (ph)
            0, 4:    return 7'b100_100_0;
            1:       return 7'b110_100_0;
            2:       return 7'b001_100_0;
            3:       return 7'b010_100_0;
            5:       return 7'b100_110_0;
            6:       return 7'b100_001_0;
            7:       return 7'b100_010_0;
            default: return 7'b100_100_1;
        endcase
    endfunction

    always @(posedge clk) begin
        int ph;
        int el;
        bit nb;
        bit w;
        cyc <= rst ? 0 : cyc + 1;
        if (rst) begin
            m_ph    <= 0;
            m_el    <= 0;
            m_wait  <= 1'b0;
            m_nb    <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            ph = m_ph;
            el = m_el;
            nb = m_nb;
            if (tick) begin
                if (el + 1 < dur_of(m_ph)) begin
                    el = el + 1;
                end else begin
                    el = 0;
                    if (PedEn && (m_ph == 0 || m_ph == 4) && (m_wait || ped_req)) begin
                        ph = 8;
                        nb = (m_ph == 4);
                    end else if (m_ph == 8) begin
                        ph = m_nb ? 5 : 1;
                    end else begin
                        ph = (m_ph + 1) % 8;
                    end
                end
            end
            if (PedEn) w = (ph == 8 && m_ph != 8) ? 1'b0 : (m_wait | ped_req);
            else w = 1'b0;
            m_ph   <= ph;
            m_el   <= el;
            m_nb   <= nb;
            m_wait <= w;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_valid) begin
            n_checks = n_checks + 2;
            if ({a_r, a_a, a_g, b_r, b_a, b_g, walk} !== lamps_of(m_ph)) begin
                n_errors = n_errors + 1;
                $display("FAIL model_lamps cyc=%0d got=%b exp=%b", cyc,
                         {a_r, a_a, a_g, b_r, b_a, b_g, walk}, lamps_of(m_ph));
            end
            if (ped_wait !== m_wait) begin
                n_errors = n_errors + 1;
                $display("FAIL model_ped_wait cyc=%0d got=%b exp=%b", cyc, ped_wait, m_wait);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle_req) ped_req = ~ped_req;
        if (tick_div4) tick = (cyc % 4 == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic goto_cycle(input int n);
        int guard = 0;
        while (cyc < n) begin
            step();
            guard++;
            if (guard > 5000) begin
                n_errors = n_errors + 1;
                $display("FAIL goto_cycle target=%0d got cyc=%0d", n, cyc);
                $fatal(1, "cycle target not reached");
            end
        end
    endtask

    task automatic expect_lamps(input string name, input logic [6:0] exp);
        n_checks = n_checks + 1;
        if ({a_r, a_a, a_g, b_r, b_a, b_g, walk} !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc,
                     {a_r, a_a, a_g, b_r, b_a, b_g, walk}, exp);
        end
    endtask

    task automatic expect_wait(input string name, input logic exp);
        n_checks = n_checks + 1;
        if (ped_wait !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, ped_wait, exp);
        end
    endtask

    initial begin
        int pin_cyc[11] = '{0, 3, 22, 23, 26, 27, 29, 48, 49, 52, 53};
        logic [6:0] pin_lmp[11] = '{7'b100_100_0, 7'b001_100_0, 7'b001_100_0, 7'b010_100_0,
                                    7'b100_100_0, 7'b100_110_0, 7'b100_001_0, 7'b001_100_0,
                                    7'b100_010_0, 7'b100_100_0, 7'b110_100_0};
        pin_lmp[7] = 7'b100_001_0;

        // Fixed cycle; in the no-pedestrian build ped_req toggles throughout
        toggle_req = !PedEn;
        do_reset();
        expect_wait("reset_wait", 1'b0);
        for (int k = 0; k < 11; k++) begin
            goto_cycle(pin_cyc[k]);
            expect_lamps("fixed_cycle", pin_lmp[k]);
        end
        expect_wait("fixed_wait", 1'b0);
        toggle_req = 1'b0;
        ped_req = 1'b0;

`ifdef TLIGHT_PED_EN
        // Pulse at 10 served after ALLRED_B
        do_reset();
        goto_cycle(10);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        expect_wait("wait_rise", 1'b1);
        goto_cycle(27);
        expect_lamps("walk_start", 7'b100_100_1);
        expect_wait("wait_clear", 1'b0);
        goto_cycle(34);
        expect_lamps("walk_end", 7'b100_100_1);
        goto_cycle(35);
        expect_lamps("after_walk_bra", 7'b100_110_0);
        goto_cycle(37);
        expect_lamps("after_walk_bg", 7'b100_001_0);

        // Reset during WALK with a pending request
        do_reset();
        goto_cycle(10);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        goto_cycle(29);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        expect_wait("rewait_in_walk", 1'b1);
        do_reset();
        expect_lamps("rst_walk_lamps", 7'b100_100_0);
        expect_wait("rst_walk_wait", 1'b0);
        goto_cycle(3);
        expect_lamps("rst_walk_restart", 7'b001_100_0);

        // Request coincident with ALLRED_B expiry, then a second during WALK
        do_reset();
        goto_cycle(26);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        expect_lamps("coinc_walk", 7'b100_100_1);
        expect_wait("coinc_wait", 1'b0);
        goto_cycle(30);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        expect_wait("second_wait", 1'b1);
        goto_cycle(60);
        expect_lamps("second_allred_a", 7'b100_100_0);
        goto_cycle(61);
        expect_lamps("second_walk", 7'b100_100_1);
        expect_wait("second_clear", 1'b0);
        goto_cycle(69);
        expect_lamps("second_ara", 7'b110_100_0);
`endif

        // Reset during B_G
        do_reset();
        goto_cycle(35);
        do_reset();
        expect_lamps("rst_bg_lamps", 7'b100_100_0);
        goto_cycle(3);
        expect_lamps("rst_bg_restart", 7'b001_100_0);

        // Tick held low for 50 cycles mid-green
        do_reset();
        goto_cycle(10);
        tick = 1'b0;
        repeat (50) step();
        expect_lamps("hold_frozen", 7'b001_100_0);
        tick = 1'b1;
        goto_cycle(72);
        expect_lamps("hold_last_green", 7'b001_100_0);
        goto_cycle(73);
        expect_lamps("hold_amber", 7'b010_100_0);

        // Tick at 1-in-4
        tick_div4 = 1'b1;
        do_reset();
        goto_cycle(8);
        expect_lamps("div4_ra_end", 7'b110_100_0);
        goto_cycle(9);
        expect_lamps("div4_green", 7'b001_100_0);
        goto_cycle(88);
        expect_lamps("div4_green_end", 7'b001_100_0);
        goto_cycle(89);
        expect_lamps("div4_amber", 7'b010_100_0);
        goto_cycle(400);
        tick_div4 = 1'b0;
        tick = 1'b1;

        // Random traffic, requests and resets
        for (int i = 0; i < 4000; i++) begin
            tick    = ($urandom_range(0, 3) != 0);
            ped_req = ($urandom_range(0, 29) == 0);
            rst     = ($urandom_range(0, 599) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tlight_junction_ctrl.md
# tlight_junction_ctrl

Two-road junction controller that sequences two UK-style traffic-light heads, road A and road B, through red, red+amber, green and amber, with an all-red clearance phase between roads. An optional pedestrian walk phase is inserted on request. Each phase lasts a parameterised number of `tick` strobes, so the block sits between a prescaler (which generates `tick`) and the lamp drivers.

## Interface
- `GREEN_TICKS`, default 20: green duration, in ticks.
- `AMBER_TICKS`, default 3: amber duration.
- `RED_AMBER_TICKS`, default 2: red+amber duration.
- `ALL_RED_TICKS`, default 1: all-red clearance duration.
- `WALK_TICKS`, default 8: pedestrian walk duration.
- All durations must be ≥1. The timer is wide enough to hold the maximum duration minus 1.

Ports:
- `clk` input, 1 bit: single clock; every register is rising-edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `tick` input, 1 bit: timer advance strobe; tie high for per-cycle timing.
- `ped_req` input, 1 bit: pedestrian request. Level or pulse; sampled every cycle.
- `a_r`, `a_a`, `a_g` output, 1 bit each: road A red, amber, green lamps.
- `b_r`, `b_a`, `b_g` output, 1 bit each: road B lamps.
- `walk` output, 1 bit: pedestrian walk lamp.
- `ped_wait` output, 1 bit: a pedestrian request is latched and not yet served.

## Operation
- Moore FSM. States, with lamps on (A / B):
  - ALLRED_A: r / r
  - A_RA: r+a / r
  - A_G: g / r
  - A_A: a / r
  - ALLRED_B: r / r
  - B_RA: r / r+a
  - B_G: r / g
  - B_A: r / a
  - WALK: r / r, `walk`=1
- Exactly one of r/g/a is lit per head, except in the RA states, where r and a are both lit.
- Fixed cycle: ALLRED_A → A_RA → A_G → A_A → ALLRED_B → B_RA → B_G → B_A → ALLRED_A.
- On expiry of ALLRED_A or ALLRED_B, if `ped_wait | ped_req` is set, the FSM enters WALK instead. It records which road is next (A after ALLRED_A, B after ALLRED_B).
- When WALK expires, the FSM goes to that road's RA state: A_RA or B_RA.
- `ped_wait` is set by `ped_req` and cleared on entry to WALK. A `ped_req` sampled during WALK, or on the WALK-entry cycle, sets `ped_wait` again, so it is served at the next all-red.
- Green is never truncated by a request. A request only diverts the FSM at an all-red expiry.
- Timer: on state entry it is loaded with duration−1. On each cycle with `tick`=1 and timer>0, it decrements. A cycle with `tick`=1 and timer==0 is the expiry: the state advances and the timer reloads. A state therefore lasts exactly its duration in ticks. With `tick`=0 the FSM and timer hold.

## Timing
- Reset, or the first cycle after `rst` deasserts, gives:
  - state ALLRED_A, timer = ALL_RED_TICKS−1, `ped_wait`=0, next-road=A
  - `a_r`=`b_r`=1; all other lamps 0; `walk`=0
- `rst` asserted mid-phase, including mid-WALK, forces this state at the next edge and discards any pending request.
- Lamp outputs decode combinationally from the state register. They change on the same edge as the state, with no extra latency.
- `ped_wait` is registered and rises one cycle after `ped_req`.
- Simultaneous `ped_req` with all-red expiry: the request is honoured in that same transition, and `ped_wait` stays 0.
- Full cycle with defaults and `tick`=1 is 52 clocks when no request is pending.

## Configuration
- `TLIGHT_PED_EN` defined: WALK state, `ped_wait` latch and next-road flag are compiled in, as described above.
- Not defined:
  - `ped_req` is ignored.
  - `walk` and `ped_wait` are tied to 0.
  - The FSM contains only the 8-state fixed cycle, and the ports remain present.

## Test plan
All scenarios use default parameters and `tick`=1 unless stated. Cycle 0 is the first cycle after reset deasserts.
- Reset, no requests: ALLRED_A at cycle 0, A_RA 1–2, A_G 3–22, A_A 23–25, ALLRED_B 26, B_RA 27–28, B_G 29–48, B_A 49–51, ALLRED_A 52. Lamp bits check every cycle; exactly one green lit at a time, never both.
- `ped_req` pulse at cycle 10: `ped_wait`=1 from cycle 11; WALK 27–34 with `walk`=1 and both heads red; `ped_wait`=0 from 27; B_RA 35–36; B_G from 37.
- `ped_req` high only on cycle 26 (ALLRED_B expiry): WALK 27–34 and `ped_wait` never rises. A second pulse at cycle 30 gives `ped_wait`=1 from 31, and the next WALK follows ALLRED_A, after which A_RA resumes.
- `tick` driven at 1-in-4 cycles: every phase length scales by exactly ×4. `tick` held low for 50 cycles mid-A_G: state and lamps frozen; green resumes with its remaining count intact.
- `rst` asserted for one cycle during WALK and during B_G: the next cycle shows ALLRED_A, `walk`=0, `ped_wait`=0, and the sequence restarts as in scenario 1.
- Build without `TLIGHT_PED_EN`, toggling `ped_req` continuously: the scenario 1 timing holds exactly, and `walk`=`ped_wait`=0 throughout.
